// File: rtl/cmac_pkg.sv
// Shared types and GF(2^128) helpers for the AES-CMAC sequencer.
package cmac_pkg;

  typedef enum logic [2:0] {
    StIdle, StSkLd, StSkWait, StMsg, StBlkLd, StBlkWait, StFin
  } state_e;

  localparam logic [127:0] RB = 128'h87;

  function automatic logic [127:0] dbl(input logic [127:0] v);
    return {v[126:0], 1'b0} ^ (v[127] ? RB : 128'h0);
  endfunction

  // Keep the first nbytes bytes, put 0x80 right after them, zero the rest.
  function automatic logic [127:0] pad_block(input logic [127:0] data, input logic [4:0] nbytes);
    logic [127:0] res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < nbytes) res[127-8*i -: 8] = data[127-8*i -: 8];
      else if (5'(i) == nbytes) res[127-8*i -: 8] = 8'h80;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmac_subkey_gen.sv
// K1/K2 derivation from L = AES_K(0), plus the key-reuse decision.
module cmac_subkey_gen
  import cmac_pkg::*;
#(
  parameter int unsigned KEY_REUSE = 1
) (
  input  logic         CLK,
  input  logic         Rst_n,
  input  logic         l_strobe,
  input  logic [127:0] l,
  input  logic         clear,
  input  logic [127:0] key_held,
  input  logic [127:0] key_new,
  output logic [127:0] k1,
  output logic [127:0] k2,
  output logic         subkey_valid,
  output logic         reuse
);

  logic [127:0] k1_d;

  always_comb begin
    k1_d  = dbl(l);
    reuse = (KEY_REUSE != 0) && subkey_valid && (key_new == key_held);
  end

  always_ff @(posedge CLK) begin
    if (!Rst_n) begin
      k1           <= '0;
      k2           <= '0;
      subkey_valid <= 1'b0;
    end else if (l_strobe) begin
      k1           <= k1_d;
      k2           <= dbl(k1_d);
      subkey_valid <= 1'b1;
    end else if (clear) begin
      subkey_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cmac_ctrl.sv
// AES-CMAC sequencer: subkey generation, CBC-MAC chaining and final-block padding
// around a single shared AES-128 core.
module cmac_ctrl
  import cmac_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned KEY_REUSE      = 1
) (
  input  logic         CLK,
  input  logic         Rst_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [127:0] msg_data,
  input  logic         msg_last,
  input  logic [4:0]   msg_bytes,
  output logic [127:0] mac,
  output logic         mac_valid,
  output logic         busy,
  output logic         error,
  output logic         aes_ld,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text_in,
  input  logic [127:0] aes_text_out,
  input  logic         aes_done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counter is 0 in the first wait cycle, so this lands error exactly
  // TIMEOUT_CYCLES cycles after the aes_ld pulse.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  state_e       state_r;
  logic [127:0] key_r;
  logic [127:0] x_r;
  logic         last_r;
  logic [CNT_W-1:0] cnt_r;

  logic [127:0] k1, k2, blk;
  logic         subkey_valid, reuse, l_strobe, timeout;

  assign aes_key = key_r;

  always_comb begin
    l_strobe = (state_r == StSkWait) && aes_done;
    timeout  = ((state_r == StSkWait) || (state_r == StBlkWait)) && !aes_done &&
               (cnt_r == CNT_LAST);
    if (!msg_last)                blk = x_r ^ msg_data;
    else if (msg_bytes >= 5'd16)  blk = x_r ^ msg_data ^ k1;
    else                          blk = x_r ^ pad_block(msg_data, msg_bytes) ^ k2;
  end

  cmac_subkey_gen #(
    .KEY_REUSE(KEY_REUSE)
  ) u_subkey (
    .CLK          (CLK),
    .Rst_n        (Rst_n),
    .l_strobe     (l_strobe),
    .l            (aes_text_out),
    .clear        (timeout),
    .key_held     (key_r),
    .key_new      (key),
    .k1           (k1),
    .k2           (k2),
    .subkey_valid (subkey_valid),
    .reuse        (reuse)
  );

  always_ff @(posedge CLK) begin
    if (!Rst_n) begin
      state_r     <= StIdle;
      key_r       <= '0;
      x_r         <= '0;
      last_r      <= 1'b0;
      cnt_r       <= '0;
      msg_ready   <= 1'b0;
      mac         <= '0;
      mac_valid   <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
      aes_ld      <= 1'b0;
      aes_text_in <= '0;
    end else begin
      mac_valid <= 1'b0;
      error     <= 1'b0;
      aes_ld    <= 1'b0;
      case (state_r)
        StIdle: begin
          if (start) begin
            key_r <= key;
            busy  <= 1'b1;
            x_r   <= '0;
            if (reuse) begin
              state_r   <= StMsg;
              msg_ready <= 1'b1;
            end else begin
              state_r     <= StSkLd;
              aes_ld      <= 1'b1;
              aes_text_in <= '0;
            end
          end
        end
        StSkLd, StBlkLd: begin
          cnt_r   <= '0;
          state_r <= (state_r == StSkLd) ? StSkWait : StBlkWait;
        end
        StSkWait, StBlkWait: begin
          if (aes_done) begin
            if (state_r == StBlkWait) x_r <= aes_text_out;
            if ((state_r == StBlkWait) && last_r) begin
              state_r <= StFin;
            end else begin
              state_r   <= StMsg;
              msg_ready <= 1'b1;
            end
          end else if (timeout) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_r <= StIdle;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        StMsg: begin
          if (msg_valid && msg_ready) begin
            msg_ready   <= 1'b0;
            aes_text_in <= blk;
            last_r      <= msg_last;
            aes_ld      <= 1'b1;
            state_r     <= StBlkLd;
          end
        end
        StFin: begin
          mac       <= x_r;
          mac_valid <= 1'b1;
          busy      <= 1'b0;
          state_r   <= StIdle;
        end
        default: state_r <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cmac_ctrl.sv
// Directed bench for cmac_ctrl against RFC 4493 vectors, with a behavioural AES-128 core.
module tb_cmac_ctrl;

  localparam int unsigned TMO     = 64;
  localparam int unsigned AES_LAT = 4;

  localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1   = 128'hfbeed618357133667c85e08f7236a8de;
  localparam logic [127:0] K2   = 128'hf7ddac306ae266ccf90bc11ee46d513b;
  localparam logic [127:0] M0   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] M1   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] M2   = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] M3   = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] T0   = 128'hbb1d6929e95937287fa37d129b756746;
  localparam logic [127:0] T16  = 128'h070a16b46b4d4144f79bdd9dd04a287c;
  localparam logic [127:0] T40  = 128'hdfa66747de9ae63030ca32611497c827;
  localparam logic [127:0] T64  = 128'h51f0bebf7e3b9d92fc49741779363cfe;

  logic         CLK = 1'b0;
  logic         Rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [127:0] msg_data = '0;
  logic         msg_last = 1'b0;
  logic [4:0]   msg_bytes = '0;
  logic [127:0] mac;
  logic         mac_valid, busy, error, aes_ld;
  logic [127:0] aes_key, aes_text_in;
  logic [127:0] aes_text_out = '0;
  logic         aes_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  cmac_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .KEY_REUSE     (1)
  ) dut (
    .CLK         (CLK),
    .Rst_n       (Rst_n),
    .start       (start),
    .key         (key),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_data    (msg_data),
    .msg_last    (msg_last),
    .msg_bytes   (msg_bytes),
    .mac         (mac),
    .mac_valid   (mac_valid),
    .busy        (busy),
    .error       (error),
    .aes_ld      (aes_ld),
    .aes_key     (aes_key),
    .aes_text_in (aes_text_in),
    .aes_text_out(aes_text_out),
    .aes_done    (aes_done)
  );

  always #5 CLK = ~CLK;

  // ---------------- AES-128 reference core ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] x, r;
      x = 8'(i);
      r = 8'h01;
      for (int j = 0; j < 254; j++) r = gmul(r, x);
      sbox[i] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
                {r[3:0], r[7:4]} ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   b [16];
    logic [127:0] st;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    st = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int n = 0; n < 16; n++) s[n] = st[127-8*n -: 8];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) b[rr+4*c] = sbox[s[rr+4*((c+rr)%4)]];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
          b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int n = 0; n < 16; n++) st[127-8*n -: 8] = b[n];
      st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return st;
  endfunction

  // Core stub: fixed latency, or swallows the operation when stall is set.
  bit           stall = 1'b0;
  logic         pend = 1'b0;
  int unsigned  lat = 0;
  logic [127:0] res = '0;

  always @(posedge CLK) begin
    aes_done <= 1'b0;
    if (!Rst_n) begin
      pend <= 1'b0;
    end else if (aes_ld) begin
      pend <= !stall;
      lat  <= AES_LAT;
      res  <= aes_enc(aes_key, aes_text_in);
    end else if (pend) begin
      if (lat == 0) begin
        aes_done     <= 1'b1;
        aes_text_out <= res;
        pend         <= 1'b0;
      end else begin
        lat <= lat - 1;
      end
    end
  end

  // Edge monitor: aes_ld bookkeeping and timeout timing.
  int cyc = 0, ld_cnt = 0, zero_ld = 0, ld_cyc = 0, err_cyc = 0;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (aes_ld) begin
      ld_cnt <= ld_cnt + 1;
      ld_cyc <= cyc;
      if (aes_text_in == '0) zero_ld <= zero_ld + 1;
    end
    if (error) err_cyc <= cyc;
  end

  // ---------------- checking and stimulus ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    start = 1'b0;
    msg_valid = 1'b0;
    repeat (3) @(negedge CLK);
    Rst_n = 1'b1;
  endtask

  task automatic kick(input logic [127:0] k);
    key   = k;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d, input logic last, input logic [4:0] nb,
                            input bit rnd);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    msg_data  = d;
    msg_last  = last;
    msg_bytes = nb;
    while (!acc && guard < 300) begin
      msg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = msg_valid && msg_ready;
      @(negedge CLK);
      guard++;
    end
    msg_valid = 1'b0;
    check("block handshake", 128'(acc), 128'd1);
  endtask

  task automatic wait_mac(input string tag, input logic [127:0] exp_mac);
    int guard;
    guard = 0;
    while (!mac_valid && guard < 500) begin
      @(negedge CLK);
      guard++;
    end
    check({tag, " mac_valid"}, 128'(mac_valid), 128'd1);
    check({tag, " mac"}, mac, exp_mac);
    check({tag, " busy with tag"}, 128'(busy), 128'd0);
    @(negedge CLK);
    check({tag, " mac_valid one cycle"}, 128'(mac_valid), 128'd0);
  endtask

  int n0, z0, guard;

  initial begin
    @(negedge CLK);
    do_reset();
    check("reset ctrl outs", 128'({msg_ready, mac_valid, busy, error, aes_ld}), 128'd0);
    check("reset mac", mac, 128'd0);
    check("reset text_in", aes_text_in, 128'd0);
    check("reset subkey_valid", 128'(dut.u_subkey.subkey_valid), 128'd0);

    // Subkey generation followed by the empty message
    n0 = ld_cnt;
    z0 = zero_ld;
    kick(KEY);
    check("busy after start", 128'(busy), 128'd1);
    guard = 0;
    while (!msg_ready && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    check("K1", dut.u_subkey.k1, K1);
    check("K2", dut.u_subkey.k2, K2);
    check("zero-block ld", 128'(zero_ld - z0), 128'd1);
    send_block({128{1'b1}}, 1'b1, 5'd0, 1'b0);
    wait_mac("empty", T0);
    check("empty ld count", 128'(ld_cnt - n0), 128'd2);

    // 16-byte message, then again with the same key (msg_bytes > 16 acts as 16)
    n0 = ld_cnt;
    z0 = zero_ld;
    kick(KEY);
    send_block(M0, 1'b1, 5'd16, 1'b0);
    wait_mac("16B", T16);
    kick(KEY);
    send_block(M0, 1'b1, 5'd20, 1'b0);
    wait_mac("16B reuse", T16);
    check("16B ld count", 128'(ld_cnt - n0), 128'd2);
    check("16B no zero-block ld", 128'(zero_ld - z0), 128'd0);

    // 40-byte message from a fresh reset, with ragged msg_valid
    do_reset();
    n0 = ld_cnt;
    kick(KEY);
    send_block(M0, 1'b0, 5'd0, 1'b1);
    send_block(M1, 1'b0, 5'd0, 1'b1);
    send_block(M2, 1'b1, 5'd8, 1'b1);
    wait_mac("40B", T40);
    check("40B ld count", 128'(ld_cnt - n0), 128'd4);

    // 64-byte message with a stray start in the middle
    n0 = ld_cnt;
    kick(KEY);
    send_block(M0, 1'b0, 5'd0, 1'b0);
    send_block(M1, 1'b0, 5'd0, 1'b0);
    kick(~KEY);
    send_block(M2, 1'b0, 5'd0, 1'b0);
    send_block(M3, 1'b1, 5'd16, 1'b0);
    wait_mac("64B", T64);
    check("64B key held", aes_key, KEY);
    check("64B ld count", 128'(ld_cnt - n0), 128'd4);

    // AES core never answers during a block
    n0 = ld_cnt;
    kick(KEY);
    stall = 1'b1;
    send_block(M0, 1'b1, 5'd16, 1'b0);
    guard = 0;
    while (!error && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    check("timeout error", 128'(error), 128'd1);
    check("timeout busy", 128'(busy), 128'd0);
    check("timeout mac held", mac, T64);
    @(negedge CLK);
    check("timeout error one cycle", 128'(error), 128'd0);
    check("timeout latency", 128'(err_cyc - ld_cyc), 128'(TMO));
    check("timeout ld count", 128'(ld_cnt - n0), 128'd1);

    // Same key again must regenerate subkeys
    stall = 1'b0;
    n0 = ld_cnt;
    kick(KEY);
    send_block(128'h0, 1'b1, 5'd0, 1'b0);
    wait_mac("regen", T0);
    check("regen ld count", 128'(ld_cnt - n0), 128'd2);

    // Reset while waiting on the core
    stall = 1'b1;
    kick(KEY);
    send_block(M0, 1'b1, 5'd16, 1'b0);
    repeat (3) @(negedge CLK);
    check("busy in blk_wait", 128'(busy), 128'd1);
    Rst_n = 1'b0;
    @(negedge CLK);
    check("mid-op reset ctrl outs", 128'({msg_ready, mac_valid, busy, error, aes_ld}), 128'd0);
    check("mid-op reset mac", mac, 128'd0);
    check("mid-op reset text_in", aes_text_in, 128'd0);
    Rst_n = 1'b1;
    stall = 1'b0;
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
